key_debounce_filter: RTL and testbench
======================================

// Module: key_debounce_filter
// PURPOSE
//   Push-button debouncer for one active-low mechanical key. Resynchronises the raw pad
//   input and times how long it stays low. Emits a single-cycle key_flag pulse once
//   the key has been stably pressed for CNT_MAX clock samples.
//   Sits between a board key pin and control logic (counters, mode selects, LED FSMs).
// PARAMETERS
//   CNT_MAX  20'd999_999  stable-low sample count before acceptance
//                         (20 ms at 50 MHz; benches use 20'd24); legal range 2..2^20-1
// PORTS
//   sys_clk    in   1  system clock, all logic on rising edge
//   sys_rst    in   1  asynchronous, active-high reset
//   key_in     in   1  raw key level, 0 = pressed, 1 = released; asynchronous, may bounce
//   key_flag   out  1  one-cycle pulse: press accepted
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high.
//   - Reset values: key_flag=0, counter=0, both synchroniser flops=1 (released).
//   - Synchroniser: 2-FF chain on key_in -> key_s. Adds 2 cycles of latency.
//   - Counter: cnt[19:0].
//       key_s==1             -> cnt<=0
//       key_s==0, cnt!=CNT_MAX -> cnt<=cnt+1
//       key_s==0, cnt==CNT_MAX -> hold (saturate; no wrap)
//   - Flag: key_flag<=1 iff key_s==0 && cnt==CNT_MAX-1, else 0.
//       Registered, so it is high exactly one cycle.
//       It rises on the CNT_MAX-th consecutive low sample of key_s.
//   - Latency: first sys_clk edge sampling key_in=0 at E -> key_flag high for the cycle
//     after edge E+1+CNT_MAX, provided key_in stays low throughout.
//   - Bounce: any key_s=1 sample clears cnt. The low run must restart from zero.
//   - Short press: a low run shorter than CNT_MAX samples produces no flag.
//   - Long hold: exactly one flag per press. The saturated counter blocks retrigger
//     until release.
//   - Release: not flagged. Bounce on release produces no flag while any high
//     sample keeps clearing cnt.
//   - Reset mid-press: everything clears immediately (async). The key must then be
//     seen low for a full CNT_MAX samples after reset deasserts.
//   - No combinational path from key_in to key_flag.
// STRUCTURE
//   - Shared package: counter width constant CNT_W=20, default CNT_MAX, and KEY_PRESSED=1'b0.
//   - Natural sub-module: sync_2ff, a generic 1-bit two-flop synchroniser with a reset
//     value parameter (here 1). Counter and flag logic stay in this module.
// TESTING  (CNT_MAX=24, 20 ns clock)
//   1) Reset held, key_in=0 -> key_flag=0, cnt=0. Release reset with key low ->
//      one flag after 26 edges.
//   2) Clean press: key_in 1->0, held 40 cycles -> exactly one key_flag pulse,
//      26 cycles after the first low sample; none after.
//   3) Bounce: random 0/1 for 11 cycles, then low 29 cycles, random 11 cycles, then high
//      (60-cycle period repeated 20 times) -> exactly one pulse per period, none in
//      bounce windows.
//   4) Short press: low 23 cycles then high -> no pulse.
//      Low 24 cycles (plus sync latency) -> one pulse.
//   5) Glitch: low 20 cycles, one high cycle, low 30 cycles -> single pulse 24 samples
//      after the glitch clears.
//   6) Async reset asserted mid-count (cnt=15) between edges -> key_flag/cnt clear at
//      once; the press re-times from 0 after release.

Source files
------------

// File: rtl/key_debounce_filter_pkg.sv
// Shared constants for the key debouncer.
//   CNT_W           width of the stable-low sample counter
//   CNT_MAX_DEFAULT default acceptance count (20 ms at 50 MHz)
//   KEY_PRESSED     key level that means "pressed" (active-low key)
package key_debounce_filter_pkg;

    localparam int unsigned       CNT_W           = 20;
    localparam logic [CNT_W-1:0]  CNT_MAX_DEFAULT = 20'd999_999;
    localparam logic              KEY_PRESSED     = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser.
//   clk  in   sampling clock
//   rst  in   asynchronous, active-high reset; both flops load RST_VAL
//   d    in   asynchronous input level
//   q    out  synchronised level, two clk cycles behind d
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_filter.sv
// Push-button debouncer for one active-low mechanical key.
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   asynchronous, active-high reset
//   key_in    in   raw key level (0 = pressed), asynchronous, may bounce
//   key_flag  out  one-cycle pulse when a press has been stable for CNT_MAX samples
module key_debounce_filter
    import key_debounce_filter_pkg::*;
#(
    parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_flag
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);

    logic             key_s;
    logic [CNT_W-1:0] cnt;

    // Reset value 1 so a reset never looks like a press.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (key_in),
        .q   (key_s)
    );

    // Saturating run-length counter of low samples; saturation blocks
    // retriggering until the key is released.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (key_s != KEY_PRESSED) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires on the CNT_MAX-th consecutive low sample only.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_flag <= 1'b0;
        end else begin
            key_flag <= (key_s == KEY_PRESSED) && (cnt == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_key_debounce_filter.sv
module tb_key_debounce_filter;

    localparam int unsigned CNT_MAX = 24;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_in  = 1'b1;
    logic key_flag;

    int   total = 0;
    int   bad   = 0;
    int   pulses = 0;
    bit   done = 1'b0;
    bit   expq[$];

    key_debounce_filter #(
        .CNT_MAX (20'd24)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key_in   (key_in),
        .key_flag (key_flag)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: length of the current run of consecutive low key_in
    // samples. A press is accepted when that run reaches exactly CNT_MAX;
    // the flag shows up two edges later because of the synchroniser.
    initial begin
        int unsigned run_now = 0;
        int unsigned run_d1  = 0;
        int unsigned run_d2  = 0;
        forever begin
            @(posedge sys_clk);
            if (sys_rst) begin
                run_now = 0;
                run_d1  = 0;
                run_d2  = 0;
                expq.push_back(1'b0);
            end else begin
                run_d2  = run_d1;
                run_d1  = run_now;
                run_now = (key_in == 1'b0) ? run_now + 1 : 0;
                expq.push_back(run_d2 == CNT_MAX);
            end
        end
    end

    // Monitor: one expected flag value per clock edge.
    initial begin
        while (!done) begin
            @(posedge sys_clk);
            #1;
            if (expq.size() == 0) begin
                check("scoreboard_empty", 0, 1);
            end else begin
                check("key_flag", int'(key_flag), int'(expq.pop_front()));
            end
            if (key_flag) pulses++;
        end
    end

    // Drive v for n clock cycles; starts and ends on a falling edge.
    task automatic drive(input logic v, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            key_in = v;
            @(negedge sys_clk);
        end
    endtask

    initial begin
        int p0;
        bit hit;

        // 1) reset held with key low, then release with key still low
        key_in  = 1'b0;
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset_flag", int'(key_flag), 0);
        check("reset_cnt", int'(dut.cnt), 0);
        p0 = pulses;
        sys_rst = 1'b0;
        drive(1'b0, 40);
        drive(1'b1, 10);
        check("reset_release_pulses", pulses - p0, 1);

        // 2) clean press held 40 cycles
        p0 = pulses;
        drive(1'b0, 40);
        drive(1'b1, 10);
        check("clean_press_pulses", pulses - p0, 1);

        // 3) bouncy presses, 60-cycle period x 20
        for (int unsigned per = 0; per < 20; per++) begin
            p0 = pulses;
            for (int unsigned i = 0; i < 11; i++) drive(1'($urandom_range(0, 1)), 1);
            drive(1'b0, 29);
            for (int unsigned i = 0; i < 11; i++) drive(1'($urandom_range(0, 1)), 1);
            drive(1'b1, 9);
            check("bounce_period_pulses", pulses - p0, 1);
        end
        drive(1'b1, 5);

        // 4) short presses around the acceptance threshold
        p0 = pulses;
        drive(1'b0, CNT_MAX - 1);
        drive(1'b1, 10);
        check("short_23_pulses", pulses - p0, 0);
        p0 = pulses;
        drive(1'b0, CNT_MAX);
        drive(1'b1, 10);
        check("short_24_pulses", pulses - p0, 1);

        // 5) single-cycle glitch restarts the count
        p0 = pulses;
        drive(1'b0, 20);
        drive(1'b1, 1);
        drive(1'b0, 30);
        drive(1'b1, 10);
        check("glitch_pulses", pulses - p0, 1);

        // 6) async reset in the middle of a count
        p0 = pulses;
        key_in = 1'b0;
        hit = 1'b0;
        for (int unsigned i = 0; i < 40 && !hit; i++) begin
            @(posedge sys_clk);
            #1;
            if (dut.cnt == 20'd15) hit = 1'b1;
        end
        check("cnt_reached_15", int'(hit), 1);
        #4 sys_rst = 1'b1;
        #1;
        check("async_rst_flag", int'(key_flag), 0);
        check("async_rst_cnt", int'(dut.cnt), 0);
        @(negedge sys_clk);
        drive(1'b0, 2);
        check("mid_press_pulses", pulses - p0, 0);
        sys_rst = 1'b0;
        drive(1'b0, CNT_MAX - 1);
        check("post_reset_early_pulses", pulses - p0, 0);
        drive(1'b0, 10);
        drive(1'b1, 10);
        check("post_reset_pulses", pulses - p0, 1);

        done = 1'b1;
        repeat (2) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
